// File: rtl/tri_bus_xcvr_if.sv
// Handshake signals between a client and the tri-state bus transceiver.
// The shared bus itself stays a plain inout port on the transceiver.
interface tri_bus_xcvr_if #(
    parameter int WIDTH = 8
);
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic             rx_req;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             busy;

    modport master (
        output tx_valid,
        output tx_data,
        output rx_req,
        input  tx_ready,
        input  rx_valid,
        input  rx_data,
        input  busy
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  rx_req,
        output tx_ready,
        output rx_valid,
        output rx_data,
        output busy
    );
endinterface

// File: rtl/tri_bus_xcvr.sv
// Half-duplex tri-state bus transceiver: drive one word, hold the bus released for
// TA_CYCLES, or sample the bus on request. Define TRI_BUS_XCVR_INV_EN for an active-low bus.
module tri_bus_xcvr #(
    parameter int WIDTH     = 8,  // 1..32
    parameter int TA_CYCLES = 2   // 1..4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tri_bus_xcvr_if.slave        xif,
    inout  tri   [WIDTH-1:0]     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        TURN   = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    localparam logic [2:0] TA_LAST = 3'(TA_CYCLES - 1);

    state_t           state, state_nx;
    logic [2:0]       ta_cnt, ta_cnt_nx;
    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] tx_out;
    logic [WIDTH-1:0] rx_in;
    logic             rx_valid_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             accept_tx;

`ifdef TRI_BUS_XCVR_INV_EN
    assign tx_out = ~tx_reg;
    assign rx_in  = ~bus;
`else
    assign tx_out = tx_reg;
    assign rx_in  = bus;
`endif

    // Async reset forces state to IDLE, so the bus is released in the same cycle.
    assign bus = (state == DRIVE) ? tx_out : {WIDTH{1'bz}};

    assign accept_tx    = (state == IDLE) && xif.tx_valid;
    assign xif.tx_ready = (state == IDLE) && rst_n;
    assign xif.busy     = (state != IDLE);
    assign xif.rx_valid = rx_valid_q;
    assign xif.rx_data  = rx_data_q;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nx  = state;
        ta_cnt_nx = ta_cnt;
        case (state)
            IDLE: begin
                // Transmit has priority; a coincident rx_req is dropped, not queued.
                if (xif.tx_valid) begin
                    state_nx = DRIVE;
                end else if (xif.rx_req) begin
                    state_nx = SAMPLE;
                end
            end
            DRIVE: begin
                state_nx  = TURN;
                ta_cnt_nx = 3'd0;
            end
            TURN: begin
                if (ta_cnt == TA_LAST) begin
                    state_nx  = IDLE;
                    ta_cnt_nx = 3'd0;
                end else begin
                    ta_cnt_nx = ta_cnt + 3'd1;
                end
            end
            SAMPLE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx  = IDLE;
                ta_cnt_nx = 3'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ta_cnt <= 3'd0;
        end else begin
            state  <= state_nx;
            ta_cnt <= ta_cnt_nx;
        end
    end

    // NOTE: the datapath registers are reset too, so an aborted transfer leaves no stale word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            if (accept_tx) begin
                tx_reg <= xif.tx_data;
            end
            if (state == SAMPLE) begin
                rx_data_q <= rx_in;
            end
            rx_valid_q <= (state == SAMPLE);
        end
    end

endmodule

// File: tb/tb_tri_bus_xcvr.sv
// Directed self-checking bench for tri_bus_xcvr (WIDTH=8, TA_CYCLES=2).
// The bus is pulled up, so a released bus reads 8'hFF.
module tb_tri_bus_xcvr;

    localparam int WIDTH = 8;
    localparam int TA    = 2;

    logic clk;
    logic rst_n;
    logic             ext_en;
    logic [WIDTH-1:0] ext_val;
    tri1  [WIDTH-1:0] bus;

    int compared;
    int mismatched;

    localparam logic [WIDTH-1:0] RELEASED = 8'hFF;

    tri_bus_xcvr_if #(.WIDTH(WIDTH)) xif ();

    tri_bus_xcvr #(.WIDTH(WIDTH), .TA_CYCLES(TA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .xif   (xif),
        .bus   (bus)
    );

    assign bus = ext_en ? ext_val : {WIDTH{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Value seen on the bus when the DUT drives word d.
    function automatic logic [WIDTH-1:0] on_bus(input logic [WIDTH-1:0] d);
`ifdef TRI_BUS_XCVR_INV_EN
        return ~d;
`else
        return d;
`endif
    endfunction

    // Value captured into rx_data when the bus carries b.
    function automatic logic [WIDTH-1:0] from_bus(input logic [WIDTH-1:0] b);
`ifdef TRI_BUS_XCVR_INV_EN
        return ~b;
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance through one rising edge and park on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        rst_n        = 1'b0;
        ext_en       = 1'b0;
        ext_val      = '0;
        xif.tx_valid = 1'b0;
        xif.tx_data  = '0;
        xif.rx_req   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_tx_ready", 32'(xif.tx_ready), 32'd0);
        check("rst_rx_valid", 32'(xif.rx_valid), 32'd0);
        check("rst_rx_data",  32'(xif.rx_data),  32'h00);
        check("rst_busy",     32'(xif.busy),     32'd0);
        check("rst_bus",      32'(bus),          32'(RELEASED));

        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(xif.tx_ready), 32'd1);

        // Transmit 3C: driven one cycle, released two, tx_ready low three cycles
        xif.tx_valid = 1'b1;
        xif.tx_data  = 8'h3C;
        #1;
        check("ready_indep_valid", 32'(xif.tx_ready), 32'd1);
        tick();
        xif.tx_valid = 1'b0;
        check("tx_drive_bus",   32'(bus),          32'(on_bus(8'h3C)));
        check("tx_drive_ready", 32'(xif.tx_ready), 32'd0);
        check("tx_drive_busy",  32'(xif.busy),     32'd1);
        tick();
        check("tx_turn1_bus",   32'(bus),          32'(RELEASED));
        check("tx_turn1_ready", 32'(xif.tx_ready), 32'd0);
        tick();
        check("tx_turn2_bus",   32'(bus),          32'(RELEASED));
        check("tx_turn2_ready", 32'(xif.tx_ready), 32'd0);
        tick();
        check("tx_done_ready",  32'(xif.tx_ready), 32'd1);
        check("tx_done_busy",   32'(xif.busy),     32'd0);

        // Receive 5A from an external driver
        ext_en     = 1'b1;
        ext_val    = 8'h5A;
        xif.rx_req = 1'b1;
        tick();
        xif.rx_req = 1'b0;
        check("rx_sample_valid", 32'(xif.rx_valid), 32'd0);
        check("rx_sample_busy",  32'(xif.busy),     32'd1);
        check("rx_sample_bus",   32'(bus),          32'h5A);
        tick();
        check("rx_pulse_valid",  32'(xif.rx_valid), 32'd1);
        check("rx_pulse_data",   32'(xif.rx_data),  32'(from_bus(8'h5A)));
        check("rx_pulse_busy",   32'(xif.busy),     32'd0);
        ext_en = 1'b0;
        tick();
        check("rx_after_valid",  32'(xif.rx_valid), 32'd0);
        check("rx_hold_data",    32'(xif.rx_data),  32'(from_bus(8'h5A)));

        // Collision: transmit wins, rx_req dropped
        xif.tx_valid = 1'b1;
        xif.tx_data  = 8'h11;
        xif.rx_req   = 1'b1;
        tick();
        xif.tx_valid = 1'b0;
        xif.rx_req   = 1'b0;
        check("col_drive_bus",  32'(bus),          32'(on_bus(8'h11)));
        check("col_rx_valid0",  32'(xif.rx_valid), 32'd0);
        tick();
        check("col_rx_valid1",  32'(xif.rx_valid), 32'd0);
        tick();
        check("col_rx_valid2",  32'(xif.rx_valid), 32'd0);
        tick();
        check("col_idle_ready", 32'(xif.tx_ready), 32'd1);
        check("col_rx_valid3",  32'(xif.rx_valid), 32'd0);
        check("col_rx_data",    32'(xif.rx_data),  32'(from_bus(8'h5A)));

        // Back-to-back with tx_valid held: the IDLE acceptance cycle adds one
        // released cycle after the TA turnaround cycles.
        xif.tx_valid = 1'b1;
        xif.tx_data  = 8'h01;
        tick();
        check("b2b_drive1", 32'(bus), 32'(on_bus(8'h01)));
        xif.tx_data = 8'h02;
        tick();
        check("b2b_z1", 32'(bus), 32'(RELEASED));
        tick();
        check("b2b_z2", 32'(bus), 32'(RELEASED));
        tick();
        check("b2b_z3_idle", 32'(bus), 32'(RELEASED));
        check("b2b_ready",   32'(xif.tx_ready), 32'd1);
        tick();
        check("b2b_drive2", 32'(bus), 32'(on_bus(8'h02)));
        xif.tx_valid = 1'b0;

        // rx_req during TURN is ignored, not queued
        tick();
        xif.rx_req = 1'b1;
        tick();
        xif.rx_req = 1'b0;
        check("turn_req_busy", 32'(xif.busy), 32'd1);
        tick();
        check("turn_req_idle", 32'(xif.busy), 32'd0);
        tick();
        check("turn_req_no_sample", 32'(xif.busy),     32'd0);
        check("turn_req_no_valid",  32'(xif.rx_valid), 32'd0);

        // Reset asserted mid-DRIVE of A5
        xif.tx_valid = 1'b1;
        xif.tx_data  = 8'hA5;
        tick();
        xif.tx_valid = 1'b0;
        check("rst_mid_drive_bus", 32'(bus), 32'(on_bus(8'hA5)));
        rst_n = 1'b0;
        #1;
        check("rst_mid_bus",      32'(bus),          32'(RELEASED));
        check("rst_mid_rx_valid", 32'(xif.rx_valid), 32'd0);
        check("rst_mid_rx_data",  32'(xif.rx_data),  32'h00);
        check("rst_mid_ready",    32'(xif.tx_ready), 32'd0);
        check("rst_mid_busy",     32'(xif.busy),     32'd0);
        tick();
        check("rst_hold_bus", 32'(bus), 32'(RELEASED));

        // First acceptance on the first edge after reset release
        @(negedge clk);
        rst_n        = 1'b1;
        xif.tx_valid = 1'b1;
        xif.tx_data  = 8'h77;
        tick();
        xif.tx_valid = 1'b0;
        check("first_accept_bus", 32'(bus), 32'(on_bus(8'h77)));
        tick();
        tick();
        tick();
        check("final_ready", 32'(xif.tx_ready), 32'd1);
        check("final_bus",   32'(bus),          32'(RELEASED));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
